// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two clients, the round-robin arbiter and the shared memory M.
// The slave modport is the arbiter's view; master is the clients-plus-memory side.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  req0;
    logic                  req1;
    logic                  write0;
    logic                  write1;
    logic [ADDR_WIDTH-1:0] address0;
    logic [ADDR_WIDTH-1:0] address1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  busy;
    logic                  memWriteEnable;
    logic [ADDR_WIDTH-1:0] memWriteAddress;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic [ADDR_WIDTH-1:0] memReadAddress;
    logic [DATA_WIDTH-1:0] memReadData;

    modport slave (
        input  req0, req1, write0, write1, address0, address1, wdata0, wdata1,
        input  memReadData,
        output ack0, ack1, rdata0, rdata1, busy,
        output memWriteEnable, memWriteAddress, memWriteData, memReadAddress
    );

    modport master (
        output req0, req1, write0, write1, address0, address1, wdata0, wdata1,
        output memReadData,
        input  ack0, ack1, rdata0, rdata1, busy,
        input  memWriteEnable, memWriteAddress, memWriteData, memReadAddress
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-client round-robin arbiter serialising single read/write accesses onto memory M.
// Each access takes IDLE -> ACCESS -> RESPOND, so one access completes every three cycles.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    memory_arbiter_if.slave  io_bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_lastGrant;
    logic                  r_winner;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  w_anyReq;
    logic                  w_grant;

    assign w_anyReq = io_bus.req0 | io_bus.req1;

    // On a tie the client that was not served last wins, giving strict alternation.
    always_comb begin
        w_grant = 1'b0;
        if (io_bus.req0 && io_bus.req1) begin
            w_grant = ~r_lastGrant;
        end else if (io_bus.req1) begin
            w_grant = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq) w_nextState = ACCESS;
            ACCESS:  w_nextState = RESPOND;
            RESPOND: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lastGrant <= 1'b1;
            r_winner    <= 1'b0;
            r_write     <= 1'b0;
            r_address   <= '0;
            r_wdata     <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_winner  <= w_grant;
                        r_write   <= w_grant ? io_bus.write1   : io_bus.write0;
                        r_address <= w_grant ? io_bus.address1 : io_bus.address0;
                        r_wdata   <= w_grant ? io_bus.wdata1   : io_bus.wdata0;
                    end
                end
                ACCESS: begin
                    // M's read path is combinational, so data is ready by the end of ACCESS.
                    if (!r_write) begin
                        if (r_winner) begin
                            r_rdata1 <= io_bus.memReadData;
                        end else begin
                            r_rdata0 <= io_bus.memReadData;
                        end
                    end
                end
                RESPOND: begin
                    r_lastGrant <= r_winner;
                end
                default: begin
                end
            endcase
        end
    end

    // Decoded straight from the state register so reset drops the write enable at once.
    assign io_bus.memWriteEnable  = (r_state == ACCESS) && r_write;
    assign io_bus.memWriteAddress = r_address;
    assign io_bus.memReadAddress  = r_address;
    assign io_bus.memWriteData    = r_wdata;
    assign io_bus.ack0            = (r_state == RESPOND) && !r_winner;
    assign io_bus.ack1            = (r_state == RESPOND) && r_winner;
    assign io_bus.busy            = (r_state != IDLE);
    assign io_bus.rdata0          = r_rdata0;
    assign io_bus.rdata1          = r_rdata1;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed client accesses push expected acks,
// and a negedge monitor pops and checks them against ack timing and read data.
module tb_memory_arbiter;

    typedef struct {
        bit          wr;
        logic [15:0] data;
        int          ackCycle;
    } exp_t;

    logic clk;
    logic rst;
    int   cycleCount;
    int   testsRun;
    int   testsFailed;
    int   weCount;
    exp_t q0[$];
    exp_t q1[$];
    logic [15:0] expRdata0;
    logic [15:0] expRdata1;
    logic [15:0] mem [0:65535] = '{default: 16'h0000};

    memory_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Behavioural model of M: combinational read, write commits on the rising edge.
    assign bus.memReadData = mem[bus.memReadAddress];
    always @(posedge clk) begin
        if (bus.memWriteEnable) mem[bus.memWriteAddress] <= bus.memWriteData;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    task automatic applyStimulus(input int client, input bit wr, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] expRd, input int ackDelay);
        exp_t e;
        bit   seen;
        int   waited;
        e.wr       = wr;
        e.data     = expRd;
        e.ackCycle = cycleCount + ackDelay;
        if (client == 0) begin
            q0.push_back(e);
            bus.write0 = wr; bus.address0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
        end else begin
            q1.push_back(e);
            bus.write1 = wr; bus.address1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
        end
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 20) begin
            @(negedge clk);
            if ((client == 0) ? bus.ack0 : bus.ack1) seen = 1'b1;
            waited++;
        end
        if (!seen) checkOutput($sformatf("ackTimeout%0d", client), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (client == 0) bus.req0 = 1'b0;
        else             bus.req1 = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        #20;
        rst = 1'b0;
        expRdata0 = '0;
        expRdata1 = '0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ack must match the oldest pending expectation of that client.
    always @(negedge clk) begin
        exp_t e;
        if (bus.memWriteEnable) weCount++;
        if (!rst) begin
            checkOutput("ackExclusive", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
            if (bus.ack0 || bus.ack1) checkOutput("ackImpliesBusy", {31'd0, bus.busy}, 32'd1);
            if (bus.ack0) begin
                if (q0.size() == 0) begin
                    checkOutput("unexpectedAck0", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    checkOutput("ack0Cycle", cycleCount, e.ackCycle);
                    if (!e.wr) expRdata0 = e.data;
                    checkOutput("rdata0", {16'd0, bus.rdata0}, {16'd0, expRdata0});
                    checkOutput("rdata1Hold", {16'd0, bus.rdata1}, {16'd0, expRdata1});
                end
            end
            if (bus.ack1) begin
                if (q1.size() == 0) begin
                    checkOutput("unexpectedAck1", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    checkOutput("ack1Cycle", cycleCount, e.ackCycle);
                    if (!e.wr) expRdata1 = e.data;
                    checkOutput("rdata1", {16'd0, bus.rdata1}, {16'd0, expRdata1});
                    checkOutput("rdata0Hold", {16'd0, bus.rdata0}, {16'd0, expRdata0});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int weBefore;
        testsRun    = 0;
        testsFailed = 0;
        weCount     = 0;
        cycleCount  = 0;
        expRdata0   = '0;
        expRdata1   = '0;
        bus.req0 = 1'b0; bus.write0 = 1'b0; bus.address0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.write1 = 1'b0; bus.address1 = '0; bus.wdata1 = '0;

        // Reset values, then ten quiet cycles with no requests.
        resetDut();
        checkOutput("rstBusy",   {31'd0, bus.busy}, 32'd0);
        checkOutput("rstAck0",   {31'd0, bus.ack0}, 32'd0);
        checkOutput("rstAck1",   {31'd0, bus.ack1}, 32'd0);
        checkOutput("rstWe",     {31'd0, bus.memWriteEnable}, 32'd0);
        checkOutput("rstRdata0", {16'd0, bus.rdata0}, 32'd0);
        checkOutput("rstRdata1", {16'd0, bus.rdata1}, 32'd0);
        checkOutput("rstWaddr",  {16'd0, bus.memWriteAddress}, 32'd0);
        checkOutput("rstRaddr",  {16'd0, bus.memReadAddress}, 32'd0);
        checkOutput("rstWdata",  {16'd0, bus.memWriteData}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idleBusy", {31'd0, bus.busy}, 32'd0);
            checkOutput("idleWe",   {31'd0, bus.memWriteEnable}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Client 0 write then read of address 3.
        weBefore = weCount;
        applyStimulus(0, 1'b1, 16'd3, 16'hBEEF, 16'h0000, 2);
        checkOutput("weOneCycle", weCount - weBefore, 32'd1);
        weBefore = weCount;
        applyStimulus(0, 1'b0, 16'd3, 16'h0000, 16'hBEEF, 2);
        checkOutput("weNoneOnRead", weCount - weBefore, 32'd0);
        checkOutput("rdata1StillZero", {16'd0, bus.rdata1}, 32'd0);

        // Ties right after reset: client 0 first, then alternation by last grant.
        resetDut();
        fork
            applyStimulus(0, 1'b1, 16'd10, 16'h1111, 16'h0000, 2);
            applyStimulus(1, 1'b1, 16'd11, 16'h2222, 16'h0000, 5);
        join
        fork
            applyStimulus(0, 1'b0, 16'd11, 16'h0000, 16'h2222, 2);
            applyStimulus(1, 1'b0, 16'd10, 16'h0000, 16'h1111, 5);
        join
        applyStimulus(0, 1'b1, 16'd12, 16'h3333, 16'h0000, 2);
        fork
            applyStimulus(0, 1'b0, 16'd12, 16'h0000, 16'h3333, 5);
            applyStimulus(1, 1'b0, 16'd12, 16'h0000, 16'h3333, 2);
        join

        // Continuous client 1 writes, then client 0 reads them back.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, 16'(i), 16'hBEEF + 16'(i), 16'h0000, 2);
        end
        applyStimulus(0, 1'b0, 16'd0, 16'h0000, 16'hBEEF, 2);
        applyStimulus(0, 1'b0, 16'd1, 16'h0000, 16'hBEF0, 2);
        applyStimulus(0, 1'b0, 16'd2, 16'h0000, 16'hBEF1, 2);
        applyStimulus(0, 1'b0, 16'd3, 16'h0000, 16'hBEF2, 2);

        // Cross-client ordering: client 0's write lands before client 1's read.
        resetDut();
        fork
            applyStimulus(0, 1'b1, 16'd7, 16'h1234, 16'h0000, 2);
            applyStimulus(1, 1'b0, 16'd7, 16'h0000, 16'h1234, 5);
        join

        // Reset during ACCESS of a write abandons it with no ack.
        bus.write0 = 1'b1; bus.address0 = 16'd5; bus.wdata0 = 16'hAAAA; bus.req0 = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("accessWeBeforeReset", {31'd0, bus.memWriteEnable}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("weDropsOnReset",   {31'd0, bus.memWriteEnable}, 32'd0);
        checkOutput("busyDropsOnReset", {31'd0, bus.busy}, 32'd0);
        bus.req0 = 1'b0;
        expRdata0 = '0;
        expRdata1 = '0;
        #20;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 16'd5, 16'h0000, 16'h0000, 2);

        repeat (4) @(posedge clk);
        checkOutput("q0Drained", q0.size(), 32'd0);
        checkOutput("q1Drained", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
